// File: rtl/tile_read_arbiter_if.sv
// Router/SRAM-side bundle for tile_read_arbiter.
// The slave modport is the arbiter; the master modport is the router/SRAM environment that drives it.
interface tile_read_arbiter_if #(
    parameter int ROW_COUNT  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ROW_COUNT-1:0]            i_req;
    logic [ROW_COUNT*ADDR_WIDTH-1:0] i_req_addr;
    logic [ROW_COUNT-1:0]            o_gnt;
    logic                            o_mem_rd_en;
    logic [ADDR_WIDTH-1:0]           o_mem_addr;
    logic [DATA_WIDTH-1:0]           i_mem_rd_data;
    logic [ROW_COUNT-1:0]            o_rsp_valid;
    logic [DATA_WIDTH-1:0]           o_rsp_data;
    logic                            o_busy;

    modport slave (
        input  i_req, i_req_addr, i_mem_rd_data,
        output o_gnt, o_mem_rd_en, o_mem_addr, o_rsp_valid, o_rsp_data, o_busy
    );

    modport master (
        output i_req, i_req_addr, i_mem_rd_data,
        input  o_gnt, o_mem_rd_en, o_mem_addr, o_rsp_valid, o_rsp_data, o_busy
    );
endinterface

// File: rtl/tile_read_arbiter.sv
// Round-robin tile-buffer read arbiter with burst lock and a 2-cycle response pipeline.
// Optional stall counter on o_stall_cnt when TILE_ARB_STATS_EN is defined.
module tile_read_arbiter #(
    parameter int ROW_COUNT  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_en,
    input  logic                  i_reg_clear,
    tile_read_arbiter_if.slave    bus
`ifdef TILE_ARB_STATS_EN
    ,
    output logic [15:0]           o_stall_cnt
`endif
);
    localparam int PW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
    localparam int CW = $clog2(BURST_LEN + 1);

    logic [PW-1:0]         ptr_q, ptr_d, owner_q, owner_d, tag_q, tag_d;
    logic                  locked_q, locked_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ROW_COUNT-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [ADDR_WIDTH-1:0] addr_arr [ROW_COUNT];
    logic [PW-1:0]         owner_wrap, base, cand, gnt_idx;
    logic                  arb_ok, cont, release_lock, accept;
    logic [ROW_COUNT-1:0]  gnt;

    for (genvar r = 0; r < ROW_COUNT; r++) begin : g_addr
        assign addr_arr[r] = bus.i_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // When the lock releases, searching from owner+1 lets the next router win in the same cycle.
    always_comb begin
        arb_ok       = i_en && i_nrst && !i_reg_clear;
        owner_wrap   = (owner_q == PW'(ROW_COUNT - 1)) ? '0 : owner_q + 1'b1;
        cont         = locked_q && bus.i_req[owner_q] && (cnt_q < CW'(BURST_LEN));
        release_lock = locked_q && !cont;
        base         = release_lock ? owner_wrap : ptr_q;
        accept       = 1'b0;
        gnt_idx      = '0;
        cand         = '0;
        if (arb_ok) begin
            if (cont) begin
                accept  = 1'b1;
                gnt_idx = owner_q;
            end else begin
                for (int unsigned i = 0; i < ROW_COUNT; i++) begin
                    cand = PW'((32'(base) + i) % ROW_COUNT);
                    if (!accept && bus.i_req[cand]) begin
                        accept  = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
        gnt = accept ? (ROW_COUNT'(1) << gnt_idx) : '0;
    end

    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        locked_d    = locked_q;
        cnt_d       = cnt_q;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        tag_d       = tag_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (rd_en_q) begin
            rsp_valid_d = ROW_COUNT'(1) << tag_q;
            rsp_data_d  = bus.i_mem_rd_data;
        end
        if (accept) begin
            rd_en_d = 1'b1;
            addr_d  = addr_arr[gnt_idx];
            tag_d   = gnt_idx;
        end
        if (arb_ok) begin
            if (release_lock) begin
                ptr_d    = owner_wrap;
                locked_d = 1'b0;
            end
            if (accept) begin
                if (cont) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    owner_d  = gnt_idx;
                    locked_d = 1'b1;
                    cnt_d    = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst || i_reg_clear) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            locked_q    <= 1'b0;
            cnt_q       <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            locked_q    <= locked_d;
            cnt_q       <= cnt_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.o_gnt       = gnt;
    assign bus.o_mem_rd_en = rd_en_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_busy      = locked_q | rd_en_q;

`ifdef TILE_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (i_en && ((bus.i_req & ~gnt) != '0) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst || i_reg_clear) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_tile_read_arbiter.sv
// Directed bench for tile_read_arbiter (ROW_COUNT=4, BURST_LEN=4); SRAM model returns addr ^ 8'h99.
module tb_tile_read_arbiter;
    logic i_clk = 1'b0;
    logic i_nrst, i_en, i_reg_clear;

    always #5 i_clk = ~i_clk;

    tile_read_arbiter_if #(.ROW_COUNT(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

`ifdef TILE_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    tile_read_arbiter #(
        .ROW_COUNT (4),
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .BURST_LEN (4)
    ) dut (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_en       (i_en),
        .i_reg_clear(i_reg_clear),
        .bus        (bus)
`ifdef TILE_ARB_STATS_EN
        ,
        .o_stall_cnt(stall_cnt)
`endif
    );

    assign bus.i_mem_rd_data = bus.o_mem_addr ^ 8'h99;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0] addr [4];
    logic       p_rd;
    logic [1:0] p_tag;
    logic [7:0] p_addr;
    logic [3:0] e_rsp_v;
    logic [7:0] e_rsp_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_addr();
        bus.i_req_addr = {addr[3], addr[2], addr[1], addr[0]};
    endtask

    // One clock: drive req/en, check the combinational grant, then the registered pipeline.
    task automatic run_cycle(input logic [3:0] req, input logic en, input logic [3:0] eg,
                             input string tag);
        int         g;
        logic       acc;
        logic [7:0] a;
        bus.i_req = req;
        i_en      = en;
        drive_addr();
        #1;
        check({tag, "_gnt"}, bus.o_gnt, eg);
        acc = (eg != 4'b0);
        g   = 0;
        for (int i = 0; i < 4; i++) if (eg[i]) g = i;
        a = addr[g];
        @(posedge i_clk);
        #1;
        e_rsp_v = p_rd ? (4'b0001 << p_tag) : 4'b0000;
        if (p_rd) e_rsp_d = p_addr ^ 8'h99;
        p_rd   = acc;
        p_tag  = g[1:0];
        p_addr = a;
        check({tag, "_rd_en"}, bus.o_mem_rd_en, p_rd);
        if (p_rd) check({tag, "_mem_addr"}, bus.o_mem_addr, p_addr);
        check({tag, "_rsp_v"}, bus.o_rsp_valid, e_rsp_v);
        if (e_rsp_v != 4'b0) check({tag, "_rsp_d"}, bus.o_rsp_data, e_rsp_d);
        if (acc) addr[g] = addr[g] + 8'd1;
    endtask

    task automatic do_clear(input string tag);
        i_reg_clear = 1'b1;
        #1;
        check({tag, "_gnt"}, bus.o_gnt, 4'b0);
        @(posedge i_clk);
        #1;
        i_reg_clear = 1'b0;
        p_rd    = 1'b0;
        e_rsp_v = 4'b0;
        e_rsp_d = 8'h00;
        check({tag, "_rd_en"}, bus.o_mem_rd_en, 1'b0);
        check({tag, "_rsp_v"}, bus.o_rsp_valid, 4'b0);
        check({tag, "_rsp_d"}, bus.o_rsp_data, 8'h00);
        check({tag, "_busy"}, bus.o_busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_nrst      = 1'b0;
        i_en        = 1'b1;
        i_reg_clear = 1'b0;
        bus.i_req   = 4'b1111;
        addr[0] = 8'h10; addr[1] = 8'h20; addr[2] = 8'h30; addr[3] = 8'h40;
        drive_addr();
        p_rd = 1'b0; p_tag = '0; p_addr = '0; e_rsp_v = '0; e_rsp_d = '0;
        #12;
        check("rst_gnt", bus.o_gnt, 4'b0);
        check("rst_rd_en", bus.o_mem_rd_en, 1'b0);
        check("rst_addr", bus.o_mem_addr, 8'h00);
        check("rst_rsp_v", bus.o_rsp_valid, 4'b0);
        check("rst_rsp_d", bus.o_rsp_data, 8'h00);
        check("rst_busy", bus.o_busy, 1'b0);
        @(posedge i_clk);
        #1;
        i_nrst    = 1'b1;
        bus.i_req = 4'b0;

        // T1: lone requester keeps the port; lock re-arms after BURST_LEN beats
        for (int k = 0; k < 6; k++) run_cycle(4'b0001, 1'b1, 4'b0001, "t1");
        check("t1_busy_on", bus.o_busy, 1'b1);
        run_cycle(4'b0000, 1'b1, 4'b0000, "t1_drain");
        run_cycle(4'b0000, 1'b1, 4'b0000, "t1_drain");
        check("t1_busy_off", bus.o_busy, 1'b0);
        do_clear("clr1");

        // T2: all request, 4-beat bursts rotate with no idle beat
        for (int k = 0; k < 17; k++)
            run_cycle(4'b1111, 1'b1, 4'b0001 << ((k / 4) % 4), "t2");
        run_cycle(4'b0000, 1'b1, 4'b0000, "t2_drain");
        run_cycle(4'b0000, 1'b1, 4'b0000, "t2_drain");

        // T3: ptr=1; r1 drops after 2 beats, r3 granted in that same cycle
        run_cycle(4'b1010, 1'b1, 4'b0010, "t3");
        run_cycle(4'b1010, 1'b1, 4'b0010, "t3");
        run_cycle(4'b1000, 1'b1, 4'b1000, "t3_sw");
        run_cycle(4'b1000, 1'b1, 4'b1000, "t3");
        run_cycle(4'b0000, 1'b1, 4'b0000, "t3_drain");
        run_cycle(4'b0000, 1'b1, 4'b0000, "t3_drain");

        // T4: address/data steering to r2
        addr[2] = 8'h3C;
        run_cycle(4'b0100, 1'b1, 4'b0100, "t4");
        check("t4_mem_addr", bus.o_mem_addr, 8'h3C);
        run_cycle(4'b0000, 1'b1, 4'b0000, "t4_drain");
        check("t4_rsp_v", bus.o_rsp_valid, 4'b0100);
        check("t4_rsp_d", bus.o_rsp_data, 8'hA5);

        // i_en low mid-burst: ptr=3, r0 holds its lock across the gap, then r1
        run_cycle(4'b0011, 1'b1, 4'b0001, "en");
        run_cycle(4'b0011, 1'b1, 4'b0001, "en");
        run_cycle(4'b0011, 1'b0, 4'b0000, "en_off");
        run_cycle(4'b0011, 1'b0, 4'b0000, "en_off");
        run_cycle(4'b0011, 1'b1, 4'b0001, "en");
        run_cycle(4'b0011, 1'b1, 4'b0001, "en");
        run_cycle(4'b0011, 1'b1, 4'b0010, "en_next");
        run_cycle(4'b0000, 1'b1, 4'b0000, "en_drain");
        run_cycle(4'b0000, 1'b1, 4'b0000, "en_drain");

        // T5: clear kills the in-flight beat and resets ptr; then async reset mid-burst
        run_cycle(4'b0100, 1'b1, 4'b0100, "t5");
        do_clear("t5_clr");
        run_cycle(4'b0000, 1'b1, 4'b0000, "t5_norsp");
        run_cycle(4'b1111, 1'b1, 4'b0001, "t5_ptr0");
        run_cycle(4'b1111, 1'b1, 4'b0001, "t5_ptr0");
        #2;
        i_nrst = 1'b0;
        #1;
        check("t5_rst_gnt", bus.o_gnt, 4'b0);
        check("t5_rst_rd_en", bus.o_mem_rd_en, 1'b0);
        check("t5_rst_addr", bus.o_mem_addr, 8'h00);
        check("t5_rst_rsp_v", bus.o_rsp_valid, 4'b0);
        check("t5_rst_rsp_d", bus.o_rsp_data, 8'h00);
        check("t5_rst_busy", bus.o_busy, 1'b0);
        p_rd = 1'b0; e_rsp_v = '0; e_rsp_d = '0;
        @(posedge i_clk);
        #1;
        i_nrst = 1'b1;
        run_cycle(4'b0010, 1'b1, 4'b0010, "t5_after");
        run_cycle(4'b0000, 1'b1, 4'b0000, "t5_after");

`ifdef TILE_ARB_STATS_EN
        // T6: one of two requesters stalls every cycle
        do_clear("t6_clr");
        for (int k = 0; k < 8; k++)
            run_cycle(4'b0011, 1'b1, (k < 4) ? 4'b0001 : 4'b0010, "t6");
        check("t6_stall", stall_cnt, 16'd8);
        do_clear("t6_clr2");
        for (int k = 0; k < 8; k++) run_cycle(4'b0011, 1'b0, 4'b0000, "t6_off");
        check("t6_stall_off", stall_cnt, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
